sipo: RTL and testbench

Serial-in parallel-out width up-converter. Collects NUM_SHIFTS narrow beats from a valid/ready/last stream and packs them into one wide word. The first beat goes to the LSB lane, so this block is the receive-side inverse of the team's PISO down-converter. It sits between narrow fabric links and wide SRAM/PE-array write ports. A stream that ends on a partial word is flushed zero-filled, with a lane count.

---
 rtl/sipo_pkg.sv | 14 +
 rtl/sipo_out_reg.sv | 54 +++++
 rtl/sipo.sv | 104 ++++++++++
 tb/tb_sipo.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/sipo_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | sipo_pkg : shared sizing helpers for the SIPO up-converter      |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
package sipo_pkg;

  // Lane count must hold the full value NUM_SHIFTS, hence the extra bit.
  function automatic int cnt_width(input int lanes);
    return $clog2(lanes) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sipo_out_reg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | sipo_out_reg : one-entry output holding register                |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
module sipo_out_reg #(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 3
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_dat,
  input  logic              i_last,
  input  logic [CNT_W-1:0]  i_cnt,
  input  logic              i_rdy,
  output logic              o_free,
  output logic [DATA_W-1:0] o_dat,
  output logic              o_vld,
  output logic              o_last,
  output logic [CNT_W-1:0]  o_cnt
);

  logic [DATA_W-1:0] r_dat;
  logic              r_vld;
  logic              r_last;
  logic [CNT_W-1:0]  r_cnt;

  // A drain and a reload in the same cycle keep r_vld high with no bubble.
  assign o_free = ~r_vld | i_rdy;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_dat  <= '0;
      r_vld  <= 1'b0;
      r_last <= 1'b0;
      r_cnt  <= '0;
    end else if (i_load) begin
      r_dat  <= i_dat;
      r_vld  <= 1'b1;
      r_last <= i_last;
      r_cnt  <= i_cnt;
    end else if (i_rdy) begin
      r_vld  <= 1'b0;
    end
  end

  assign o_dat  = r_dat;
  assign o_vld  = r_vld;
  assign o_last = r_last;
  assign o_cnt  = r_cnt;

endmodule
`default_nettype wire

// File: rtl/sipo.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | sipo : serial-in parallel-out width up-converter, lane0 = LSBs  |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
module sipo
  import sipo_pkg::*;
#(
  parameter int DATA_IN_WIDTH  = 16,
  parameter int DATA_OUT_WIDTH = 64,
  localparam int NUM_SHIFTS    = DATA_OUT_WIDTH / DATA_IN_WIDTH,
  localparam int CNT_W         = cnt_width(NUM_SHIFTS)
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  input  logic                      IN_VLD,
  input  logic                      IN_LAST,
  input  logic [DATA_IN_WIDTH-1:0]  IN_DAT,
  output logic                      IN_RDY,
  output logic [DATA_OUT_WIDTH-1:0] OUT_DAT,
  output logic                      OUT_VLD,
  output logic                      OUT_LAST,
  output logic [CNT_W-1:0]          OUT_CNT,
  input  logic                      OUT_RDY
);

  localparam int IDX_W = CNT_W - 1;

  logic [DATA_OUT_WIDTH-1:0] r_asm;
  logic [IDX_W-1:0]          r_cnt;
  logic                      r_asm_done;

  logic                      w_out_free;
  logic                      w_last_lane;
  logic                      w_accept;
  logic                      w_complete;
  logic                      w_load;
  logic [DATA_OUT_WIDTH-1:0] w_asm_new;
  logic [DATA_OUT_WIDTH-1:0] w_load_dat;
  logic                      w_load_last;
  logic [CNT_W-1:0]          w_cnt_p1;

  assign w_last_lane = (r_cnt == IDX_W'(NUM_SHIFTS - 1));
  assign IN_RDY      = ~r_asm_done & (~w_last_lane | w_out_free);
  assign w_accept    = IN_VLD & IN_RDY;
  assign w_complete  = w_accept & (w_last_lane | IN_LAST);
  assign w_cnt_p1    = {1'b0, r_cnt} + CNT_W'(1);

  // Lanes above r_cnt are already zero because r_asm is cleared on every hand-off.
  for (genvar l = 0; l < NUM_SHIFTS; l++) begin : g_lane
    assign w_asm_new[l*DATA_IN_WIDTH +: DATA_IN_WIDTH] =
      (r_cnt == IDX_W'(l)) ? IN_DAT : r_asm[l*DATA_IN_WIDTH +: DATA_IN_WIDTH];
  end

  // A held flush has priority; IN_RDY is low while it waits so no beat competes.
  assign w_load      = w_out_free & (r_asm_done | w_complete);
  assign w_load_dat  = r_asm_done ? r_asm : w_asm_new;
  assign w_load_last = r_asm_done | IN_LAST;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_asm      <= '0;
      r_cnt      <= '0;
      r_asm_done <= 1'b0;
    end else if (r_asm_done) begin
      if (w_out_free) begin
        r_asm      <= '0;
        r_cnt      <= '0;
        r_asm_done <= 1'b0;
      end
    end else if (w_accept) begin
      if (w_complete && w_out_free) begin
        r_asm <= '0;
        r_cnt <= '0;
      end else if (w_complete) begin
        r_asm      <= w_asm_new;
        r_asm_done <= 1'b1;
      end else begin
        r_asm <= w_asm_new;
        r_cnt <= r_cnt + IDX_W'(1);
      end
    end
  end

  sipo_out_reg #(
    .DATA_W (DATA_OUT_WIDTH),
    .CNT_W  (CNT_W)
  ) u_out_reg (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .i_load (w_load),
    .i_dat  (w_load_dat),
    .i_last (w_load_last),
    .i_cnt  (w_cnt_p1),
    .i_rdy  (OUT_RDY),
    .o_free (w_out_free),
    .o_dat  (OUT_DAT),
    .o_vld  (OUT_VLD),
    .o_last (OUT_LAST),
    .o_cnt  (OUT_CNT)
  );

endmodule
`default_nettype wire

// File: tb/tb_sipo.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | tb_sipo : scoreboard bench for the SIPO up-converter (16 -> 64) |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
module tb_sipo;

  localparam int DIW = 16;
  localparam int DOW = 64;
  localparam int NS  = DOW / DIW;
  localparam int CW  = 3;

  typedef struct {
    logic [DOW-1:0] dat;
    logic           last;
    logic [CW-1:0]  cnt;
  } exp_t;

  logic           CLK = 1'b0;
  logic           RST_N = 1'b0;
  logic           IN_VLD = 1'b0;
  logic           IN_LAST = 1'b0;
  logic [DIW-1:0] IN_DAT = '0;
  logic           IN_RDY;
  logic [DOW-1:0] OUT_DAT;
  logic           OUT_VLD;
  logic           OUT_LAST;
  logic [CW-1:0]  OUT_CNT;
  logic           OUT_RDY = 1'b0;

  int             n_chk = 0;
  int             n_pass = 0;
  int             n_stall = 0;
  int             cyc = 0;
  bit             rdy_rand = 1'b0;

  exp_t           expq[$];
  logic [DIW-1:0] cur[$];

  sipo #(.DATA_IN_WIDTH(DIW), .DATA_OUT_WIDTH(DOW)) dut (
    .CLK(CLK), .RST_N(RST_N), .IN_VLD(IN_VLD), .IN_LAST(IN_LAST), .IN_DAT(IN_DAT),
    .IN_RDY(IN_RDY), .OUT_DAT(OUT_DAT), .OUT_VLD(OUT_VLD), .OUT_LAST(OUT_LAST),
    .OUT_CNT(OUT_CNT), .OUT_RDY(OUT_RDY)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc++;

  always @(posedge CLK) begin
    if (rdy_rand) begin
      #1;
      OUT_RDY = ($urandom_range(3) != 0);
    end
  end

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference: collect accepted beats; a word closes when it is full or the beat is last.
  task automatic model_accept(input logic [DIW-1:0] d, input logic l);
    exp_t e;
    cur.push_back(d);
    if (cur.size() == NS || l) begin
      e.dat  = '0;
      foreach (cur[i]) e.dat = e.dat | (DOW'(cur[i]) << (DIW * i));
      e.last = l;
      e.cnt  = CW'(cur.size());
      expq.push_back(e);
      cur.delete();
    end
  endtask

  task automatic drive_beat(input logic [DIW-1:0] d, input logic l);
    int n = 0;
    IN_VLD = 1'b1; IN_DAT = d; IN_LAST = l;
    @(negedge CLK);
    while (!IN_RDY && n < 200) begin
      n++; n_stall++;
      @(negedge CLK);
    end
    if (!IN_RDY) chk("accept_timeout", 80'd0, 80'd1);
    else model_accept(d, l);
    @(posedge CLK); #1;
    IN_VLD = 1'b0; IN_LAST = 1'b0; IN_DAT = DIW'($urandom);
  endtask

  task automatic wait_drain();
    int n = 0;
    OUT_RDY = 1'b1;
    while ((expq.size() != 0 || OUT_VLD) && n < 50) begin
      @(posedge CLK); #1; n++;
    end
    chk("drain", 80'(expq.size() == 0 && !OUT_VLD), 80'd1);
  endtask

  // Monitor: pop and compare on every output transfer; enforce stability while stalled.
  logic [DOW-1:0] h_dat;
  logic           h_last;
  logic [CW-1:0]  h_cnt;
  bit             hold_p = 1'b0;
  always @(negedge CLK) begin
    exp_t e;
    if (!RST_N) hold_p = 1'b0;
    else begin
      if (hold_p)
        chk("hold_stable", {11'd0, OUT_VLD, OUT_LAST, OUT_CNT, OUT_DAT},
                           {11'd0, 1'b1, h_last, h_cnt, h_dat});
      if (OUT_VLD && OUT_RDY) begin
        if (expq.size() == 0) chk("unexpected_word", {12'd0, OUT_CNT, OUT_DAT}, 80'd0);
        else begin
          e = expq.pop_front();
          chk("out_word", {12'd0, OUT_LAST, OUT_CNT, OUT_DAT}, {12'd0, e.last, e.cnt, e.dat});
        end
      end
      hold_p = OUT_VLD && !OUT_RDY;
      h_dat = OUT_DAT; h_last = OUT_LAST; h_cnt = OUT_CNT;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, c0;
    logic [DIW-1:0] d;
    #1;
    chk("reset_out", {12'd0, OUT_VLD, OUT_LAST, OUT_CNT, OUT_DAT}, 80'd0);
    chk("reset_in_rdy", 80'(IN_RDY), 80'd1);
    #13 RST_N = 1'b1;
    @(posedge CLK); #1;

    // 1: one full word, latency and no stalls
    OUT_RDY = 1'b1; s0 = n_stall;
    drive_beat(16'h1111, 0); drive_beat(16'h2222, 0);
    drive_beat(16'h3333, 0); drive_beat(16'h4444, 0);
    chk("t1_latency_vld", 80'(OUT_VLD), 80'd1);
    chk("t1_no_stall", 80'(n_stall - s0), 80'd0);
    wait_drain();

    // 2: full word then a partial flushed word
    for (int i = 1; i <= 6; i++) begin
      d = DIW'(i * 16'h1111);
      drive_beat(d, i == 6);
    end
    wait_drain();

    // 3: final lane blocked while the output is stalled, then reload with no bubble
    OUT_RDY = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      d = DIW'(i * 16'h1111);
      drive_beat(d, 0);
    end
    IN_VLD = 1'b1; IN_DAT = 16'h8888;
    chk("t3_final_lane_blocked", 80'(IN_RDY), 80'd0);
    repeat (2) begin @(posedge CLK); #1; end
    chk("t3_still_blocked", 80'(IN_RDY), 80'd0);
    OUT_RDY = 1'b1;
    drive_beat(16'h8888, 0);
    OUT_RDY = 1'b0;
    chk("t3_no_bubble", {15'd0, OUT_VLD, OUT_DAT}, {15'd0, 1'b1, 64'h8888777766665555});
    repeat (2) begin @(posedge CLK); #1; end
    wait_drain();

    // 4: lone last beat while the output is held
    OUT_RDY = 1'b0;
    for (int i = 1; i <= 4; i++) drive_beat(DIW'(i), 0);
    drive_beat(16'hABCD, 1);
    chk("t4_rdy_low", 80'(IN_RDY), 80'd0);
    @(posedge CLK); #1;
    chk("t4_rdy_still_low", 80'(IN_RDY), 80'd0);
    OUT_RDY = 1'b1;
    @(posedge CLK); #1;
    chk("t4_rdy_back", {78'd0, IN_RDY, OUT_VLD}, 80'd3);
    wait_drain();

    // 5: asynchronous reset mid-word discards partial data
    drive_beat(16'hDEAD, 0); drive_beat(16'hBEEF, 0);
    #3 RST_N = 1'b0;
    #1;
    chk("t5_reset_out", {12'd0, OUT_VLD, OUT_LAST, OUT_CNT, OUT_DAT}, 80'd0);
    chk("t5_reset_in_rdy", 80'(IN_RDY), 80'd1);
    cur.delete(); expq.delete();
    #2 RST_N = 1'b1;
    @(posedge CLK); #1;
    for (int i = 10; i <= 13; i++) drive_beat(DIW'(i), 0);
    wait_drain();

    // 6: eight back-to-back beats at full rate
    c0 = cyc; s0 = n_stall;
    for (int i = 0; i < 8; i++) drive_beat(DIW'($urandom), 0);
    chk("t6_cycles", 80'(cyc - c0), 80'd8);
    chk("t6_no_stall", 80'(n_stall - s0), 80'd0);
    wait_drain();

    // Random traffic with random backpressure and gaps
    rdy_rand = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(3) == 0) begin
        repeat ($urandom_range(3, 1)) begin @(posedge CLK); #1; end
      end
      drive_beat(DIW'($urandom), $urandom_range(4) == 0);
    end
    if (cur.size() != 0) drive_beat(DIW'($urandom), 1);
    rdy_rand = 1'b0;
    @(posedge CLK); #1;
    wait_drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
